// File: rtl/schmidl_cox_sync_ctrl.sv
// rtl/schmidl_cox_sync_ctrl.sv - Schmidl-Cox timing-metric plateau detector and frame gate
// Register block, search/plateau/frame FSM and zero-latency sample gating.
module schmidl_cox_sync_ctrl #(
  parameter int METRIC_W = 32,
  parameter int CNT_W    = 16
) (
  input  logic                ce_clk,
  input  logic                ce_rst_n,
  input  logic                s_ctrlport_req_wr,
  input  logic                s_ctrlport_req_rd,
  input  logic [19:0]         s_ctrlport_req_addr,
  input  logic [31:0]         s_ctrlport_req_data,
  output logic                s_ctrlport_resp_ack,
  output logic [31:0]         s_ctrlport_resp_data,
  input  logic [31:0]         s_axis_tdata,
  input  logic [METRIC_W-1:0] s_axis_tmetric,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [31:0]         m_axis_tdata,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                frame_start,
  output logic [1:0]          sync_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEARCH  = 2'd1,
    S_PLATEAU = 2'd2,
    S_FRAME   = 2'd3
  } state_t;

  localparam logic [19:0]      A_THRESHOLD = 20'h00000;
  localparam logic [19:0]      A_PLAT_MIN  = 20'h00004;
  localparam logic [19:0]      A_FRAME_LEN = 20'h00008;
  localparam logic [19:0]      A_CTRL      = 20'h0000C;
  localparam logic [19:0]      A_STATUS    = 20'h00010;
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  state_t              state;
  logic [METRIC_W-1:0] threshold;
  logic [CNT_W-1:0]    plateau_min;
  logic [CNT_W-1:0]    frame_len;
  logic                ctrl_enable;
  logic                ctrl_oneshot;
  logic [CNT_W-1:0]    run_cnt;
  logic [CNT_W-1:0]    frame_cnt;
  logic [CNT_W-1:0]    latched_len;
  logic [CNT_W-1:0]    frame_count;

  logic                above;
  logic                s_hs;
  logic                m_hs;
  logic                frame_done;
  logic [CNT_W-1:0]    plateau_eff;
  logic [CNT_W-1:0]    frame_len_eff;
  logic [CNT_W:0]      run_next;
  logic [31:0]         rd_mux;

  assign above         = s_axis_tmetric > threshold;
  assign plateau_eff   = (plateau_min == '0) ? ONE : plateau_min;
  assign frame_len_eff = (frame_len == '0) ? ONE : frame_len;
  assign run_next      = {1'b0, run_cnt} + {1'b0, ONE};
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_hs          = m_axis_tvalid && m_axis_tready;
  assign frame_done    = m_hs && m_axis_tlast;
  assign sync_state    = state;

  // In PLATEAU only not-above samples are forwarded; the first one opens the frame.
  always_comb begin
    s_axis_tready = 1'b1;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    frame_start   = 1'b0;
    case (state)
      S_PLATEAU: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid && !above;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tvalid && !above && (frame_len_eff == ONE);
        frame_start   = s_axis_tvalid && !above && m_axis_tready;
      end
      S_FRAME: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tvalid && (frame_cnt == latched_len - ONE);
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (s_ctrlport_req_addr)
      A_THRESHOLD: rd_mux = 32'(threshold);
      A_PLAT_MIN:  rd_mux = 32'(plateau_min);
      A_FRAME_LEN: rd_mux = 32'(frame_len);
      A_CTRL:      rd_mux = {30'd0, ctrl_oneshot, ctrl_enable};
      A_STATUS:    rd_mux = {16'(frame_count), 14'd0, state};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      threshold            <= '0;
      plateau_min          <= ONE;
      frame_len            <= ONE;
      ctrl_enable          <= 1'b0;
      ctrl_oneshot         <= 1'b0;
      s_ctrlport_resp_ack  <= 1'b0;
      s_ctrlport_resp_data <= '0;
    end else begin
      s_ctrlport_resp_ack  <= s_ctrlport_req_wr || s_ctrlport_req_rd;
      s_ctrlport_resp_data <= '0;
      if (s_ctrlport_req_wr) begin
        case (s_ctrlport_req_addr)
          A_THRESHOLD: threshold   <= s_ctrlport_req_data[METRIC_W-1:0];
          A_PLAT_MIN:  plateau_min <= s_ctrlport_req_data[CNT_W-1:0];
          A_FRAME_LEN: frame_len   <= s_ctrlport_req_data[CNT_W-1:0];
          A_CTRL: begin
            ctrl_enable  <= s_ctrlport_req_data[0];
            ctrl_oneshot <= s_ctrlport_req_data[1];
          end
          default: ;
        endcase
      end else if (s_ctrlport_req_rd) begin
        s_ctrlport_resp_data <= rd_mux;
      end
      // A oneshot frame disarms the block even if software touches CTRL that cycle.
      if (frame_done && ctrl_oneshot) begin
        ctrl_enable <= 1'b0;
      end
    end
  end

  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      state       <= S_IDLE;
      run_cnt     <= '0;
      frame_cnt   <= '0;
      latched_len <= ONE;
      frame_count <= '0;
    end else if (frame_done) begin
      frame_count <= frame_count + ONE;
      run_cnt     <= '0;
      state       <= (ctrl_oneshot || !ctrl_enable) ? S_IDLE : S_SEARCH;
    end else begin
      case (state)
        S_IDLE: begin
          if (ctrl_enable) begin
            state   <= S_SEARCH;
            run_cnt <= '0;
          end
        end
        S_SEARCH: begin
          if (!ctrl_enable) begin
            state   <= S_IDLE;
            run_cnt <= '0;
          end else if (s_hs) begin
            if (above) begin
              run_cnt <= run_next[CNT_W] ? run_cnt : run_next[CNT_W-1:0];
              if (run_next >= {1'b0, plateau_eff}) begin
                state <= S_PLATEAU;
              end
            end else begin
              run_cnt <= '0;
            end
          end
        end
        S_PLATEAU: begin
          if (m_hs) begin
            latched_len <= frame_len_eff;
            frame_cnt   <= ONE;
            state       <= S_FRAME;
          end else if (!ctrl_enable) begin
            state   <= S_IDLE;
            run_cnt <= '0;
          end
        end
        S_FRAME: begin
          if (m_hs) begin
            frame_cnt <= frame_cnt + ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
